// File: rtl/txn_step_sequencer.sv
// Transaction step sequencer: walks steps 1..NUM_STEPS on per-step done inputs,
// with a per-step watchdog, abort, error reporting and a completed-transaction counter.
module txn_step_sequencer #(
  parameter int NUM_STEPS = 4,
  parameter int STEP_W    = 3,
  parameter int TIMEOUT   = 1023,
  parameter int CNT_W     = 16
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM_STEPS-1:0] step_done,
  output logic [STEP_W-1:0]    step,
  output logic                 step_start,
  output logic                 busy,
  output logic                 txn_done,
  output logic                 txn_error,
  output logic [1:0]           err_code,
  output logic [STEP_W-1:0]    err_step,
  output logic [CNT_W-1:0]     txn_count
);

  localparam bit WDOG_EN = (TIMEOUT != 0);
  localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_TIMEOUT = 2'b01,
    ERR_ABORT   = 2'b10
  } err_e;

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                busy_q, busy_d;
  logic                step_start_q, step_start_d;
  logic                txn_done_q, txn_done_d;
  logic                txn_error_q, txn_error_d;
  err_e                err_code_q, err_code_d;
  logic [STEP_W-1:0]   err_step_q, err_step_d;
  logic [CNT_W-1:0]    txn_count_q, txn_count_d;

  logic cur_done;
  logic last_step;
  logic timeout_hit;

  // Select the done bit of the current step; step 0 (idle) selects nothing.
  always_comb begin
    cur_done = 1'b0;
    for (int i = 0; i < NUM_STEPS; i++) begin
      if (step_q == STEP_W'(i + 1)) cur_done = step_done[i];
    end
  end

  assign last_step   = (step_q == STEP_W'(NUM_STEPS));
  assign timeout_hit = WDOG_EN && (timer_q == TIMER_W'(TIMEOUT - 1));

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned -- otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    timer_d      = timer_q;
    busy_d       = busy_q;
    step_start_d = 1'b0;
    txn_done_d   = 1'b0;
    txn_error_d  = 1'b0;
    err_code_d   = err_code_q;
    err_step_d   = err_step_q;
    txn_count_d  = txn_count_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_RUN;
          step_d       = STEP_W'(1);
          busy_d       = 1'b1;
          step_start_d = 1'b1;
          timer_d      = '0;
          err_code_d   = ERR_NONE;
          err_step_d   = '0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d     = S_IDLE;
          step_d      = '0;
          busy_d      = 1'b0;
          timer_d     = '0;
          txn_error_d = 1'b1;
          err_code_d  = ERR_ABORT;
          err_step_d  = step_q;
        end else if (cur_done) begin
          timer_d = '0;
          if (last_step) begin
            state_d     = S_IDLE;
            step_d      = '0;
            busy_d      = 1'b0;
            txn_done_d  = 1'b1;
            txn_count_d = txn_count_q + 1'b1;
          end else begin
            step_d       = step_q + 1'b1;
            step_start_d = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d     = S_IDLE;
          step_d      = '0;
          busy_d      = 1'b0;
          timer_d     = '0;
          txn_error_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          err_step_d  = step_q;
        end else if (WDOG_EN) begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      step_q       <= '0;
      timer_q      <= '0;
      busy_q       <= 1'b0;
      step_start_q <= 1'b0;
      txn_done_q   <= 1'b0;
      txn_error_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
      err_step_q   <= '0;
      txn_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      timer_q      <= timer_d;
      busy_q       <= busy_d;
      step_start_q <= step_start_d;
      txn_done_q   <= txn_done_d;
      txn_error_q  <= txn_error_d;
      err_code_q   <= err_code_d;
      err_step_q   <= err_step_d;
      txn_count_q  <= txn_count_d;
    end
  end

  assign step       = step_q;
  assign step_start = step_start_q;
  assign busy       = busy_q;
  assign txn_done   = txn_done_q;
  assign txn_error  = txn_error_q;
  assign err_code   = err_code_q;
  assign err_step   = err_step_q;
  assign txn_count  = txn_count_q;

endmodule

// File: tb/tb_txn_step_sequencer.sv
// Bench for txn_step_sequencer: a cycle model checked every cycle, directed scenarios
// with literal expectations, and a watchdog-disabled instance.
module tb_txn_step_sequencer;

  localparam int NS = 4;
  localparam int TO = 8;
  localparam int CW = 4;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] step_done = 4'b0000;

  logic [2:0]    step;
  logic          step_start, busy, txn_done, txn_error;
  logic [1:0]    err_code;
  logic [2:0]    err_step;
  logic [CW-1:0] txn_count;

  logic       start_nt = 1'b0;
  logic       abort_nt = 1'b0;
  logic [3:0] done_nt = 4'b0000;

  logic [2:0]    step_nt;
  logic          step_start_nt, busy_nt, txn_done_nt, txn_error_nt;
  logic [1:0]    err_code_nt;
  logic [2:0]    err_step_nt;
  logic [CW-1:0] txn_count_nt;

  txn_step_sequencer #(.NUM_STEPS(NS), .STEP_W(3), .TIMEOUT(TO), .CNT_W(CW)) u_dut (
    .clock(clock), .resetn(resetn), .start(start), .abort(abort), .step_done(step_done),
    .step(step), .step_start(step_start), .busy(busy), .txn_done(txn_done),
    .txn_error(txn_error), .err_code(err_code), .err_step(err_step), .txn_count(txn_count)
  );

  txn_step_sequencer #(.NUM_STEPS(NS), .STEP_W(3), .TIMEOUT(0), .CNT_W(CW)) u_nowdog (
    .clock(clock), .resetn(resetn), .start(start_nt), .abort(abort_nt), .step_done(done_nt),
    .step(step_nt), .step_start(step_start_nt), .busy(busy_nt), .txn_done(txn_done_nt),
    .txn_error(txn_error_nt), .err_code(err_code_nt), .err_step(err_step_nt),
    .txn_count(txn_count_nt)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Cycle model: the current step and how many cycles it has lasted so far.
  int m_step = 0, m_age = 0, m_count = 0, m_code = 0, m_err_step = 0;
  bit m_step_start = 0, m_done = 0, m_err = 0;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_step = 0; m_age = 0; m_count = 0; m_code = 0; m_err_step = 0;
      m_step_start = 0; m_done = 0; m_err = 0;
    end else begin
      m_step_start = 0; m_done = 0; m_err = 0;
      if (m_step == 0) begin
        if (start) begin
          m_step = 1; m_age = 1; m_step_start = 1; m_code = 0; m_err_step = 0;
        end
      end else if (abort) begin
        m_err = 1; m_code = 2; m_err_step = m_step; m_step = 0;
      end else if (step_done[m_step-1]) begin
        if (m_step == NS) begin
          m_done = 1; m_count = (m_count + 1) % (1 << CW); m_step = 0;
        end else begin
          m_step = m_step + 1; m_age = 1; m_step_start = 1;
        end
      end else if (TO != 0 && m_age == TO) begin
        m_err = 1; m_code = 1; m_err_step = m_step; m_step = 0;
      end else begin
        m_age = m_age + 1;
      end
    end
  end

  always begin
    @(posedge clock);
    #1;
    check("step",       32'(step),       m_step);
    check("busy",       32'(busy),       32'(m_step != 0));
    check("step_start", 32'(step_start), 32'(m_step_start));
    check("txn_done",   32'(txn_done),   32'(m_done));
    check("txn_error",  32'(txn_error),  32'(m_err));
    check("err_code",   32'(err_code),   m_code);
    check("err_step",   32'(err_step),   m_err_step);
    check("txn_count",  32'(txn_count),  m_count);
  end

  bit nt_err_seen = 0;
  always @(posedge clock) if (txn_error_nt === 1'b1) nt_err_seen = 1;

  int starts_seen;

  initial begin
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    check("reset_step", 32'(step), 0);
    check("reset_count", 32'(txn_count), 0);

    // 1: dones tied high, minimum-length transaction
    start = 1'b1; step_done = 4'b1111;
    starts_seen = 0;
    for (int s = 1; s <= NS; s++) begin
      tick();
      start = 1'b0;
      check("t1_step", 32'(step), s);
      starts_seen += int'(step_start);
    end
    tick();
    check("t1_done_step", 32'(step), 0);
    check("t1_done", 32'(txn_done), 1);
    check("t1_count", 32'(txn_count), 1);
    check("t1_step_starts", starts_seen, 4);
    step_done = 4'b0000;
    tick();

    // 2: step 1 never completes -> timeout in its 8th cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 2; c <= TO; c++) begin
      tick();
      check("t2_hold_step", 32'(step), 1);
    end
    tick();
    check("t2_error", 32'(txn_error), 1);
    check("t2_code", 32'(err_code), 1);
    check("t2_err_step", 32'(err_step), 1);
    check("t2_busy", 32'(busy), 0);
    check("t2_count", 32'(txn_count), 1);
    tick();

    // 3: abort beats done in step 3
    start = 1'b1;
    tick();
    start = 1'b0; step_done = 4'b0001;
    tick();
    step_done = 4'b0010;
    tick();
    check("t3_step3", 32'(step), 3);
    step_done = 4'b0100; abort = 1'b1;
    tick();
    abort = 1'b0; step_done = 4'b0000;
    check("t3_error", 32'(txn_error), 1);
    check("t3_code", 32'(err_code), 2);
    check("t3_err_step", 32'(err_step), 3);
    check("t3_step", 32'(step), 0);
    tick();
    check("t3_code_held", 32'(err_code), 2);

    // 4: start held, 16 back-to-back transactions, counter wraps
    start = 1'b1; step_done = 4'b1111;
    for (int k = 0; k < 16; k++) begin
      tick();
      check("t4_first_step", 32'(step), 1);
      if (k == 0) begin
        check("t4_code_clr", 32'(err_code), 0);
        check("t4_err_step_clr", 32'(err_step), 0);
      end
      repeat (NS - 1) tick();
      tick();
      check("t4_done", 32'(txn_done), 1);
      check("t4_count", 32'(txn_count), (2 + k) % 16);
      if (k == 15) start = 1'b0;
    end
    step_done = 4'b0000;
    tick();
    check("t4_idle", 32'(step), 0);

    // 5: only non-current dones asserted in step 2
    start = 1'b1;
    tick();
    start = 1'b0; step_done = 4'b0001;
    tick();
    step_done = 4'b1001;
    repeat (TO - 1) begin
      tick();
      check("t5_hold_step", 32'(step), 2);
    end
    tick();
    check("t5_error", 32'(txn_error), 1);
    check("t5_code", 32'(err_code), 1);
    check("t5_err_step", 32'(err_step), 2);
    step_done = 4'b0000;
    tick();

    // 6: asynchronous reset mid-step 2
    start = 1'b1;
    tick();
    start = 1'b0; step_done = 4'b0001;
    tick();
    step_done = 4'b0000;
    check("t6_step2", 32'(step), 2);
    #3 resetn = 1'b0;
    #1;
    check("t6_async_step", 32'(step), 0);
    check("t6_async_busy", 32'(busy), 0);
    check("t6_async_count", 32'(txn_count), 0);
    check("t6_async_pulses", 32'({txn_done, txn_error, step_start}), 0);
    tick();
    tick();
    resetn = 1'b1;
    tick();
    check("t6_post_step", 32'(step), 0);
    check("t6_post_code", 32'(err_code), 0);

    // 7: watchdog disabled instance holds step 1 indefinitely
    start_nt = 1'b1;
    tick();
    start_nt = 1'b0;
    repeat (5000) tick();
    check("t7_step", 32'(step_nt), 1);
    check("t7_busy", 32'(busy_nt), 1);
    check("t7_no_error", 32'(nt_err_seen), 0);
    done_nt = 4'b0001;
    tick();
    done_nt = 4'b0000;
    check("t7_advance", 32'(step_nt), 2);
    abort_nt = 1'b1;
    tick();
    abort_nt = 1'b0;
    check("t7_abort_code", 32'(err_code_nt), 2);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
